// File: rtl/synth_pkg.sv
// Shared constants for the keypad sawtooth synth.
// Holds the note table, the increment ROM and the keypad map.
package synth_pkg;

  localparam int ACC_WIDTH  = 32;
  localparam int ADDR_WIDTH = 9;
  localparam int WIDTH      = 24;
  localparam int FS         = 48000;

  localparam int unsigned NOTE_HZ [16] = '{
    261, 294, 330, 349, 392, 440, 494, 523,
    587, 659, 698, 784, 880, 988, 1046, 1174
  };

  function automatic logic [ACC_WIDTH-1:0] calc_inc(
    input int unsigned f
  );
    logic [63:0] num;
    num = 64'(f) << 32;
    return ACC_WIDTH'(num / 64'(FS));
  endfunction

  // Folded to constants at elaboration; no divider is built.
  localparam logic [ACC_WIDTH-1:0] INC_ROM [16] = '{
    calc_inc(NOTE_HZ[0]),  calc_inc(NOTE_HZ[1]),
    calc_inc(NOTE_HZ[2]),  calc_inc(NOTE_HZ[3]),
    calc_inc(NOTE_HZ[4]),  calc_inc(NOTE_HZ[5]),
    calc_inc(NOTE_HZ[6]),  calc_inc(NOTE_HZ[7]),
    calc_inc(NOTE_HZ[8]),  calc_inc(NOTE_HZ[9]),
    calc_inc(NOTE_HZ[10]), calc_inc(NOTE_HZ[11]),
    calc_inc(NOTE_HZ[12]), calc_inc(NOTE_HZ[13]),
    calc_inc(NOTE_HZ[14]), calc_inc(NOTE_HZ[15])
  };

  function automatic logic [ACC_WIDTH-1:0] note_inc(
    input logic [3:0] n
  );
    return INC_ROM[n];
  endfunction

  // [row][col]; star maps to E, hash to F
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

endpackage

// File: rtl/keypad_saw_synth_phase_acc.sv
// Free-running phase accumulator; top bits form the
// waveform address.
module phase_acc
  import synth_pkg::*;
(
  input  logic                  clk_48kHz,
  input  logic                  rst_n,
  input  logic [ACC_WIDTH-1:0]  inc,
  output logic [ADDR_WIDTH-1:0] addr
);

  logic [ACC_WIDTH-1:0] acc;

  always_ff @(posedge clk_48kHz) begin
    if (!rst_n) acc <= '0;
    else        acc <= acc + inc;
  end

  assign addr = acc[ACC_WIDTH-1 -: ADDR_WIDTH];

endmodule

// File: rtl/keypad_saw_synth.sv
// Keypad scanner/decoder driving a phase-continuous
// sawtooth oscillator.
module keypad_saw_synth
  import synth_pkg::*;
#(
  parameter int SCAN_DIV = 1024
) (
  input  logic                  clk_48kHz,
  input  logic                  rst_n,
  input  logic [3:0]            kpyd_row_i,
  output logic [3:0]            kpyd_col_o,
  output logic [3:0]            hex_o,
  output logic                  key_valid_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0]      saw_o,
  output logic                  saw_valid_o
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] cnt;
  logic [3:0]       col;
  logic             scan_end;
  logic [3:0]       row_low;
  logic [3:0]       row_sel;
  logic             one_row;
  logic [1:0]       r_idx;
  logic [1:0]       c_idx;

  assign scan_end   = (cnt == CNT_W'(SCAN_DIV - 1));
  assign kpyd_col_o = ~col;

  // Chords and ghosts are rejected before the one-hot decode.
  always_comb begin
    row_low = ~kpyd_row_i;
    one_row = (row_low != 4'd0) &&
              ((row_low & (row_low - 4'd1)) == 4'd0);
    row_sel = one_row ? row_low : 4'b0001;
    r_idx   = 2'd0;
    c_idx   = 2'd0;
    unique case (1'b1)
      row_sel[0]: r_idx = 2'd0;
      row_sel[1]: r_idx = 2'd1;
      row_sel[2]: r_idx = 2'd2;
      row_sel[3]: r_idx = 2'd3;
      default:    r_idx = 2'd0;
    endcase
    unique case (1'b1)
      col[0]:  c_idx = 2'd0;
      col[1]:  c_idx = 2'd1;
      col[2]:  c_idx = 2'd2;
      col[3]:  c_idx = 2'd3;
      default: c_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk_48kHz) begin
    if (!rst_n) begin
      cnt         <= '0;
      col         <= 4'b0001;
      hex_o       <= 4'd0;
      key_valid_o <= 1'b0;
    end else begin
      cnt         <= scan_end ? '0 : cnt + 1'b1;
      key_valid_o <= 1'b0;
      if (scan_end) begin
        col <= {col[2:0], col[3]};
        if (one_row) begin
          hex_o       <= KEYMAP[r_idx][c_idx];
          key_valid_o <= 1'b1;
        end
      end
    end
  end

  phase_acc u_acc (
    .clk_48kHz (clk_48kHz),
    .rst_n     (rst_n),
    .inc       (note_inc(hex_o)),
    .addr      (addr_o)
  );

  // MSB flip turns the unsigned ramp into a signed one.
  always_ff @(posedge clk_48kHz) begin
    if (!rst_n) begin
      saw_o       <= '0;
      saw_valid_o <= 1'b0;
    end else begin
      saw_o <= {~addr_o[ADDR_WIDTH-1],
                addr_o[ADDR_WIDTH-2:0],
                {(WIDTH-ADDR_WIDTH){1'b0}}};
      saw_valid_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_keypad_saw_synth.sv
// Scoreboard bench: cycle reference model feeds a queue,
// a negedge monitor pops and compares.
module tb_keypad_saw_synth;

  localparam int SD = 1024;

  logic        clk_48kHz;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  hex;
  logic        key_valid;
  logic [8:0]  addr;
  logic [23:0] saw;
  logic        saw_valid;

  int total  = 0;
  int passed = 0;

  keypad_saw_synth #(.SCAN_DIV(SD)) dut (
    .clk_48kHz   (clk_48kHz),
    .rst_n       (rst_n),
    .kpyd_row_i  (row),
    .kpyd_col_o  (col),
    .hex_o       (hex),
    .key_valid_o (key_valid),
    .addr_o      (addr),
    .saw_o       (saw),
    .saw_valid_o (saw_valid)
  );

  initial begin
    clk_48kHz = 1'b0;
    forever #5 clk_48kHz = ~clk_48kHz;
  end

  localparam int FREQ [16] = '{
    261, 294, 330, 349, 392, 440, 494, 523,
    587, 659, 698, 784, 880, 988, 1046, 1174
  };
  localparam int KEYS [4][4] = '{
    '{1, 2, 3, 10},
    '{4, 5, 6, 11},
    '{7, 8, 9, 12},
    '{14, 0, 15, 13}
  };

  function automatic bit [31:0] inc_of(input int n);
    longint unsigned num;
    num = longint'(FREQ[n]) * 64'h1_0000_0000;
    return 32'(num / 48000);
  endfunction

  typedef struct {
    logic [3:0]  col;
    logic [3:0]  hex;
    logic        kv;
    logic [8:0]  addr;
    logic [23:0] saw;
    logic        sv;
  } exp_t;

  exp_t q[$];

  int        m_cnt, m_col, m_hex;
  bit        m_kv, m_sv;
  bit [31:0] m_acc;
  bit [23:0] m_saw;

  always @(posedge clk_48kHz) begin
    int        lows, r, hx_old;
    bit [31:0] a_old;
    exp_t      e;
    if (!rst_n) begin
      m_cnt = 0; m_col = 0; m_hex = 0; m_kv = 0;
      m_acc = 0; m_saw = 0; m_sv = 0;
    end else begin
      a_old  = m_acc;
      hx_old = m_hex;
      m_kv   = 0;
      if (m_cnt == SD - 1) begin
        lows = 0; r = 0;
        for (int i = 0; i < 4; i++)
          if (!row[i]) begin lows++; r = i; end
        if (lows == 1) begin
          m_hex = KEYS[r][m_col];
          m_kv  = 1;
        end
        m_col = (m_col + 1) % 4;
      end
      m_cnt = (m_cnt + 1) % SD;
      m_saw = 24'((int'(a_old >> 23) - 256) * 32768);
      m_acc = a_old + inc_of(hx_old);
      m_sv  = 1;
    end
    e.col  = ~(4'b0001 << m_col);
    e.hex  = 4'(m_hex);
    e.kv   = m_kv;
    e.addr = 9'(m_acc >> 23);
    e.saw  = m_saw;
    e.sv   = m_sv;
    q.push_back(e);
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  int wraps = 0;
  logic [23:0] last_saw = '0;

  always @(negedge clk_48kHz) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (col === e.col && hex === e.hex &&
          key_valid === e.kv && addr === e.addr &&
          saw === e.saw && saw_valid === e.sv)
        passed++;
      else
        $display({"FAIL cycle t=%0t: got col=%b hex=%h kv=%b",
                  " addr=%0d saw=%h sv=%b expected col=%b",
                  " hex=%h kv=%b addr=%0d saw=%h sv=%b"},
                 $time, col, hex, key_valid, addr, saw,
                 saw_valid, e.col, e.hex, e.kv, e.addr,
                 e.saw, e.sv);
      if (saw_valid && $signed(saw) < $signed(last_saw))
        wraps++;
      last_saw = saw;
    end
  end

  int pulses;

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk_48kHz);
      if (key_valid === 1'b1) pulses++;
    end
  endtask

  initial begin
    bit found;
    int ch, a, b;
    row   = 4'hF;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_48kHz);
    chk("reset_col", 32'(col), 32'(4'b1110));
    chk("reset_hex", 32'(hex), 32'd0);
    chk("reset_saw", 32'(saw), 32'd0);
    chk("reset_sv",  32'(saw_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk_48kHz);
    chk("sv_after_release", 32'(saw_valid), 32'd1);

    pulses = 0;
    run(4096);
    chk("idle_pulses", 32'(pulses), 32'd0);

    found = 0;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(negedge clk_48kHz);
      if (col === 4'b1011) found = 1;
    end
    chk("wait_col2", 32'(found), 32'd1);
    row    = 4'b1101;
    pulses = 0;
    run(1100);
    row = 4'hF;
    chk("key6_hex", 32'(hex), 32'd6);
    chk("key6_pulses", 32'(pulses), 32'd1);
    run(3000);
    chk("key6_hold", 32'(hex), 32'd6);

    row    = 4'b1100;
    pulses = 0;
    run(4096);
    chk("ghost_hex", 32'(hex), 32'd6);
    chk("ghost_pulses", 32'(pulses), 32'd0);

    for (int it = 0; it < 14; it++) begin
      ch = $urandom_range(0, 3);
      a  = $urandom_range(0, 3);
      b  = (a + $urandom_range(1, 3)) % 4;
      if (ch == 0)      row = 4'hF;
      else if (ch == 3) row = ~((4'b1 << a) | (4'b1 << b));
      else              row = ~(4'b1 << a);
      run($urandom_range(300, 2500));
      if (it == 7) begin
        rst_n = 1'b0;
        @(negedge clk_48kHz);
        chk("midrst_col", 32'(col), 32'(4'b1110));
        chk("midrst_hex", 32'(hex), 32'd0);
        chk("midrst_addr", 32'(addr), 32'd0);
        rst_n = 1'b1;
      end
    end
    chk("saw_wrapped", 32'(wraps > 0), 32'd1);
    @(negedge clk_48kHz);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
